// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    localparam logic [31:0] DBZ_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_ITER,
        DIV_FIX
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is 2^31 unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned restoring shift-subtract divider core: one quotient bit per step, 32 steps.
module div_core
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] rem,
    output logic [31:0] quo,
    output logic        last
);

    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [32:0]      trial;
    logic [31:0]      shifted;

    // quo_q starts as the dividend and fills with quotient bits from the right.
    assign shifted = {rem_q[30:0], quo_q[31]};
    assign trial   = {1'b0, shifted} - {1'b0, dvsr_q};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        if (load) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvsr_d = divisor;
            cnt_d  = '0;
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted;
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (clr) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rem  = rem_q;
    assign quo  = quo_q;
    assign last = (cnt_q == CNT_W'(DIV_ITERS - 1));

endmodule

// File: rtl/mul32s.sv
// Combinational signed 32x32 -> 64 multiplier with the same interface as the Booth multiplier.
module mul32s (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    assign p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

endmodule

// File: rtl/hi_lo_mdu.sv
// HI/LO multiply/divide unit: shared start/busy/done handshake for MUL and signed DIV.
module hi_lo_mdu
    import mdu_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] HI_RESET = 32'h0,
    parameter logic [WIDTH-1:0] LO_RESET = 32'h0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] bus_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        sgn_quo_q, sgn_quo_d, sgn_rem_q, sgn_rem_d;
    logic        dbz_pend_q, dbz_pend_d;
    logic        dbz_q, dbz_d, busy_q, busy_d, done_q, done_d;
    logic        div_load, div_step, div_last;
    logic [31:0] div_rem, div_quo;
    logic [63:0] product;

    mul32s u_mul (
        .a (a_q),
        .b (b_q),
        .p (product)
    );

    div_core u_div (
        .clk      (clk),
        .clr      (clr),
        .load     (div_load),
        .step     (div_step),
        .dividend (abs32(src_a)),
        .divisor  (abs32(src_b)),
        .rem      (div_rem),
        .quo      (div_quo),
        .last     (div_last)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        sgn_quo_d  = sgn_quo_q;
        sgn_rem_d  = sgn_rem_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        div_load   = 1'b0;
        div_step   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Direct writes land now; a launched operation overwrites them at done.
                if (hi_wr) hi_d = bus_in;
                if (lo_wr) lo_d = bus_in;
                if (start) begin
                    a_d        = src_a;
                    b_d        = src_b;
                    dbz_d      = 1'b0;
                    dbz_pend_d = 1'b0;
                    if (op == OP_MUL) begin
                        state_d = MUL_WAIT;
                    end else if (src_b == '0) begin
                        dbz_pend_d = 1'b1;
                        state_d    = DIV_FIX;
                    end else begin
                        div_load  = 1'b1;
                        sgn_quo_d = src_a[31] ^ src_b[31];
                        sgn_rem_d = src_a[31];
                        state_d   = DIV_ITER;
                    end
                end
            end
            MUL_WAIT: begin
                {hi_d, lo_d} = product;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            DIV_ITER: begin
                div_step = 1'b1;
                if (div_last) state_d = DIV_FIX;
            end
            DIV_FIX: begin
                if (dbz_pend_q) begin
                    hi_d  = a_q;
                    lo_d  = DBZ_LO;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = sgn_quo_q ? -div_quo : div_quo;
                    hi_d = sgn_rem_q ? -div_rem : div_rem;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= HI_RESET;
            lo_q       <= LO_RESET;
            sgn_quo_q  <= 1'b0;
            sgn_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            sgn_quo_q  <= sgn_quo_d;
            sgn_rem_q  <= sgn_rem_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hi_lo_mdu.sv
// Randomized and directed bench for hi_lo_mdu against a plain-arithmetic reference model.
module tb_hi_lo_mdu;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0, op = 1'b0, hi_wr = 1'b0, lo_wr = 1'b0;
    logic [31:0] src_a = '0, src_b = '0, bus_in = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    hi_lo_mdu dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .bus_in      (bus_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result: signed 64-bit product, or C-style truncating divide.
    function automatic void ref_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el,
                                   output logic edbz, output int elat);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        edbz = 1'b0;
        if (!o) begin
            p = sa * sb;
            eh = p[63:32];
            el = p[31:0];
            elat = 1;
        end else if (b == 32'h0) begin
            eh = a;
            el = 32'hFFFF_FFFF;
            edbz = 1'b1;
            elat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            eh = r[31:0];
            el = q[31:0];
            elat = 33;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op; optionally poke start/hi_wr/lo_wr at wait cycle poke_cyc while busy.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input int poke_cyc);
        logic [31:0] eh, el;
        logic        edbz;
        int          elat, lat;
        ref_op(o, a, b, eh, el, edbz, elat);
        start = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        lat = 0;
        while (!done && lat < 60) begin
            if (lat == poke_cyc) begin
                start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom;
                hi_wr = 1'b1; lo_wr = 1'b1; bus_in = $urandom;
            end
            tick();
            start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
            lat++;
        end
        check(o ? "div_latency" : "mul_latency", 64'(lat), 64'(elat));
        check(o ? "div_hi" : "mul_hi", 64'(hi), 64'(eh));
        check(o ? "div_lo" : "mul_lo", 64'(lo), 64'(el));
        check("dbz_flag", 64'(div_by_zero), 64'(edbz));
        check("busy_at_done", 64'(busy), 64'(0));
    endtask

    initial begin
        int dones;
        logic [31:0] ra, rb;
        #12;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        clr = 1'b0;
        tick();

        run_op(1'b0, 32'd6, 32'd7, -1);
        run_op(1'b0, 32'hFFFF_FFFD, 32'd5, -1);      // back-to-back in the done cycle
        run_op(1'b1, 32'd100, 32'd7, 9);              // ignored start + writes at N+10
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(1'b1, 32'd5, 32'd0, -1);
        tick();
        check("done_one_cycle", 64'(done), 64'(0));
        check("dbz_sticky", 64'(div_by_zero), 64'(1));
        run_op(1'b0, 32'd3, 32'd4, -1);               // accepted start clears the flag

        // Direct writes in IDLE, then a coinciding start and write.
        tick();
        lo_wr = 1'b1; hi_wr = 1'b1; bus_in = 32'h1234;
        tick();
        lo_wr = 1'b0; hi_wr = 1'b0;
        check("lo_wr_idle", 64'(lo), 64'h1234);
        check("hi_wr_idle", 64'(hi), 64'h1234);
        start = 1'b1; op = 1'b0; src_a = 32'd2; src_b = 32'd3; lo_wr = 1'b1; bus_in = 32'hCAFE;
        tick();
        start = 1'b0; lo_wr = 1'b0;
        check("wr_wins_edge", 64'(lo), 64'hCAFE);
        check("op_launched", 64'(busy), 64'(1));
        tick();
        check("op_overwrites", 64'(lo), 64'd6);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'(int'($urandom_range(1, 20)) - 10);
                default: ;
            endcase
            if (rb == 32'h0 && $urandom_range(0, 1) == 0) rb = 32'd1;
            run_op(1'($urandom_range(0, 1)), ra, rb, ($urandom_range(0, 1) == 1) ? 0 : -1);
        end

        // Asynchronous clear mid-divide aborts with no done pulse.
        tick();
        start = 1'b1; op = 1'b1; src_a = 32'd100; src_b = 32'd7;
        tick();
        start = 1'b0;
        repeat (14) tick();
        #3 clr = 1'b1;
        #1;
        check("clr_hi", 64'(hi), 64'(0));
        check("clr_lo", 64'(lo), 64'(0));
        check("clr_busy", 64'(busy), 64'(0));
        check("clr_done", 64'(done), 64'(0));
        tick();
        clr = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) dones++;
        end
        check("no_done_after_clr", 64'(dones), 64'(0));
        check("idle_after_clr", 64'(busy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
